// File: rtl/imm_ext_pipe.sv
// rtl/imm_ext_pipe.sv - two-stage pipelined immediate extension unit with valid/ready and flush
//
// Purpose: extends an IMM_W-bit immediate to a DATA_W-bit operand between
// decode and execute. Stage 1 captures the request, stage 2 holds the
// computed result that drives the outputs directly.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   flush      - synchronous squash of all in-flight entries
//   in_valid   - upstream request valid
//   in_ready   - request accepted this cycle
//   in_imm     - raw immediate (IMM_W)
//   in_op      - 00 zero, 01 sign, 10 upper, 11 branch (sign-extend, <<2)
//   in_tag     - sideband tag (TAG_W), carried unchanged
//   out_valid  - result valid
//   out_ready  - downstream accepts result
//   out_data   - extended operand (DATA_W)
//   out_tag    - tag of this result
//   out_lost   - branch mode only: significant bits shifted out

module imm_ext_pipe #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_op,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_lost
);

  localparam int EXT_W = DATA_W - IMM_W;

  // Stage 1 registers
  logic [IMM_W-1:0] imm1;
  logic [1:0]       op1;
  logic [TAG_W-1:0] tag1;
  logic             v1;

  // Stage 2 registers
  logic [DATA_W-1:0] data2;
  logic [TAG_W-1:0]  tag2;
  logic              lost2;
  logic              v2;

  // Ready chain: a stage can take new data if it is empty or drains this cycle.
  logic r1;
  logic r2;

  assign r2       = !v2 || out_ready;
  assign r1       = !v1 || r2;
  assign in_ready = r1 && !flush;

  assign out_valid = v2;
  assign out_data  = data2;
  assign out_tag   = tag2;
  assign out_lost  = lost2;

  // Extension arithmetic on stage-1 contents.
  logic [DATA_W-1:0] sext;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ext_data;
  logic              ext_lost;

  always_comb begin
    sext     = {{EXT_W{imm1[IMM_W-1]}}, imm1};
    shifted  = sext << 2;
    ext_data = '0;
    ext_lost = 1'b0;
    case (op1)
      2'b00: ext_data = {{EXT_W{1'b0}}, imm1};
      2'b01: ext_data = sext;
      2'b10: ext_data = {imm1, {EXT_W{1'b0}}};
      2'b11: begin
        ext_data = shifted;
        // The two bits pushed out must both equal the new sign bit, otherwise
        // the offset no longer fits. Always 0 while DATA_W >= IMM_W+2.
        ext_lost = (sext[DATA_W-1] != shifted[DATA_W-1]) ||
                   (sext[DATA_W-2] != shifted[DATA_W-1]);
      end
      default: ext_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      data2 <= '0;
      tag2  <= '0;
      lost2 <= 1'b0;
    end else if (flush) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (r1) begin
        v1 <= in_valid;
        if (in_valid) begin
          imm1 <= in_imm;
          op1  <= in_op;
          tag1 <= in_tag;
        end
      end
      if (r2) begin
        v2 <= v1;
        if (v1) begin
          data2 <= ext_data;
          tag2  <= tag1;
          lost2 <= ext_lost;
        end
      end
    end
  end

endmodule
